// File: rtl/reg_wr_queue.sv
// reg_wr_queue: small in-order FIFO between a register-write requester and a
// register bank. Accepted requests are issued one per cycle as a registered
// write strobe with matching address/data and a clock-gate enable.
// Optional feature: define REG_WR_QUEUE_ADDRCHECK_EN to drop requests whose
// address is not one of ADDR_RED/ADDR_BLUE/ADDR_GREEN and count the drops.
module reg_wr_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_RED   = 123,
  parameter int unsigned ADDR_BLUE  = 456,
  parameter int unsigned ADDR_GREEN = 789
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_clkgate,
  output logic [7:0]        o_nDropped
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W+DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic                     r_write;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_data;

  logic w_handshake;
  logic w_addr_ok;
  logic w_push;
  logic w_pop;

  // Ready depends only on the stored occupancy, never on i_valid.
  assign o_ready     = (r_count < CW'(DEPTH));
  assign w_handshake = i_valid && o_ready && !i_flush;
  assign w_push      = w_handshake && w_addr_ok;
  assign w_pop       = (r_count != '0) && !i_stall && !i_flush;

  assign o_write   = r_write;
  assign o_clkgate = r_write;
  assign o_addr    = r_addr;
  assign o_data    = r_data;

`ifdef REG_WR_QUEUE_ADDRCHECK_EN
  logic [7:0] r_dropped;

  assign w_addr_ok = (i_addr == ADDR_W'(ADDR_RED))  ||
                     (i_addr == ADDR_W'(ADDR_BLUE)) ||
                     (i_addr == ADDR_W'(ADDR_GREEN));
  assign o_nDropped = r_dropped;

  // Count consumed-but-rejected requests, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dropped <= '0;
    end else if (w_handshake && !w_addr_ok && (r_dropped != '1)) begin
      r_dropped <= r_dropped + 8'd1;
    end
  end
`else
  assign w_addr_ok  = 1'b1;
  assign o_nDropped = '0;
`endif

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_addr, i_data};
    end
  end

  // Queue pointers, occupancy and the registered issue port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else if (i_flush) begin
      // Address/data keep their last issued values across a flush.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_write  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_write  <= 1'b1;
        {r_addr, r_data} <= r_mem[r_rd_ptr];
      end else begin
        r_write <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_wr_queue.sv
// Scoreboard bench for reg_wr_queue: stimulus pushes expected issues into a
// queue, a negedge monitor pops and compares whenever o_write is high.
module tb_reg_wr_queue;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_addr;
  logic [31:0] i_data;
  logic        i_stall;
  logic        i_flush;
  logic        o_write;
  logic [15:0] o_addr;
  logic [31:0] o_data;
  logic        o_clkgate;
  logic [7:0]  o_nDropped;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  reg_wr_queue #(
    .DEPTH(4),
    .ADDR_W(16),
    .DATA_W(32),
    .ADDR_RED(123),
    .ADDR_BLUE(456),
    .ADDR_GREEN(789)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_addr(i_addr),
    .i_data(i_data),
    .i_stall(i_stall),
    .i_flush(i_flush),
    .o_write(o_write),
    .o_addr(o_addr),
    .o_data(o_data),
    .o_clkgate(o_clkgate),
    .o_nDropped(o_nDropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [15:0] a, input logic [31:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    return e;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && o_write) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h expected no strobe", o_addr, o_data);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("sb_addr", 64'(o_addr), 64'(e.a));
        chk("sb_data", 64'(o_data), 64'(e.d));
        chk("sb_clkgate", 64'(o_clkgate), 64'd1);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addrs [3];
    addrs[0] = 16'd123;
    addrs[1] = 16'd456;
    addrs[2] = 16'd789;
    rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_data = '0; i_stall = 1'b0; i_flush = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_write",   64'(o_write), 64'd0);
    chk("rst_clkgate", 64'(o_clkgate), 64'd0);
    chk("rst_addr",    64'(o_addr), 64'd0);
    chk("rst_data",    64'(o_data), 64'd0);
    chk("rst_dropped", 64'(o_nDropped), 64'd0);
    chk("rst_ready",   64'(o_ready), 64'd1);
    rst = 1'b0;
    chk("ready_after_rst", 64'(o_ready), 64'd1);

    // Single push, two-cycle latency, one-cycle strobe, hold afterwards
    @(negedge clk);
    i_valid = 1'b1; i_addr = 16'd123; i_data = 32'hA5;
    chk("t1_ready", 64'(o_ready), 64'd1);
    exp_q.push_back(mk(16'd123, 32'hA5));
    @(negedge clk);
    i_valid = 1'b0;
    chk("t1_no_early_write", 64'(o_write), 64'd0);
    @(negedge clk);
    chk("t1_strobe", 64'(o_write), 64'd1);
    @(negedge clk);
    chk("t1_strobe_one_cycle", 64'(o_write), 64'd0);
    chk("t1_hold_addr", 64'(o_addr), 64'd123);
    chk("t1_hold_data", 64'(o_data), 64'hA5);

    // Fill under stall, fifth request refused, then consecutive drain
    i_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_addr = addrs[i % 3]; i_data = 32'h100 + 32'(i);
      chk("t2_ready_fill", 64'(o_ready), 64'd1);
      exp_q.push_back(mk(addrs[i % 3], 32'h100 + 32'(i)));
      @(negedge clk);
    end
    i_addr = 16'd789; i_data = 32'hDEAD;
    chk("t2_full_ready", 64'(o_ready), 64'd0);
    @(negedge clk);
    chk("t2_full_ready_hold", 64'(o_ready), 64'd0);
    i_valid = 1'b0; i_stall = 1'b0;
    @(negedge clk);
    chk("t2_ready_back", 64'(o_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_consecutive", 64'(o_write), 64'd1);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    chk("t2_drained", 64'(o_write), 64'd0);

    // Full queue with pop in the same cycle: push only on the next cycle
    i_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_addr = addrs[(i + 1) % 3]; i_data = 32'h200 + 32'(i);
      exp_q.push_back(mk(addrs[(i + 1) % 3], 32'h200 + 32'(i)));
      @(negedge clk);
    end
    i_stall = 1'b0; i_valid = 1'b1; i_addr = 16'd456; i_data = 32'h2FF;
    chk("t3_full_no_push", 64'(o_ready), 64'd0);
    @(negedge clk);
    chk("t3_ready_after_pop", 64'(o_ready), 64'd1);
    exp_q.push_back(mk(16'd456, 32'h2FF));
    @(negedge clk);
    i_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Flush with three queued entries and a simultaneous request
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_addr = addrs[i]; i_data = 32'h300 + 32'(i);
      exp_q.push_back(mk(addrs[i], 32'h300 + 32'(i)));
      @(negedge clk);
    end
    i_flush = 1'b1; i_valid = 1'b1; i_addr = 16'd123; i_data = 32'h3FF;
    chk("t4_ready_before_flush", 64'(o_ready), 64'd1);
    repeat (3) void'(exp_q.pop_back());
    @(negedge clk);
    i_flush = 1'b0; i_valid = 1'b0; i_stall = 1'b0;
    chk("t4_ready_after_flush", 64'(o_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_write", 64'(o_write), 64'd0);
      @(negedge clk);
    end

    // Address filtering and drop counter
    i_valid = 1'b1; i_addr = 16'd100; i_data = 32'h400;
`ifndef REG_WR_QUEUE_ADDRCHECK_EN
    exp_q.push_back(mk(16'd100, 32'h400));
`endif
    @(negedge clk);
    i_addr = 16'd456; i_data = 32'h401;
    exp_q.push_back(mk(16'd456, 32'h401));
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4) @(negedge clk);
`ifdef REG_WR_QUEUE_ADDRCHECK_EN
    chk("t5_dropped_one", 64'(o_nDropped), 64'd1);
    i_valid = 1'b1; i_addr = 16'd100; i_data = 32'h4FF;
    repeat (300) @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    chk("t5_dropped_sat", 64'(o_nDropped), 64'd255);
`else
    chk("t5_dropped_zero", 64'(o_nDropped), 64'd0);
`endif

    // Asynchronous reset while strobing with two entries still queued
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_addr = addrs[i]; i_data = 32'h500 + 32'(i);
      exp_q.push_back(mk(addrs[i], 32'h500 + 32'(i)));
      @(negedge clk);
    end
    i_valid = 1'b0; i_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_write_before_rst", 64'(o_write), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_write",   64'(o_write), 64'd0);
    chk("t6_rst_clkgate", 64'(o_clkgate), 64'd0);
    chk("t6_rst_addr",    64'(o_addr), 64'd0);
    chk("t6_rst_data",    64'(o_data), 64'd0);
    chk("t6_rst_dropped", 64'(o_nDropped), 64'd0);
    chk("t6_rst_ready",   64'(o_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_strobe", 64'(o_write), 64'd0);
    end

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_wr_queue.md
REG_WR_QUEUE -- requirements
Module: reg_wr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning write data width.
REQ-004 SHALL have parameters ADDR_RED/ADDR_BLUE/ADDR_GREEN, defaults 123/456/789, meaning the decoded register addresses.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port i_valid  input  1  upstream write request present.
REQ-008 SHALL have port o_ready  output  1  queue can accept a request this cycle.
REQ-009 SHALL have port i_addr  input  ADDR_W  request address.
REQ-010 SHALL have port i_data  input  DATA_W  request data.
REQ-011 SHALL have port i_stall  input  1  downstream bank forbids issue this cycle.
REQ-012 SHALL have port i_flush  input  1  discard all queued requests.
REQ-013 SHALL have port o_write  output  1  one-cycle write strobe to the register bank.
REQ-014 SHALL have port o_addr  output  ADDR_W  issued address, valid when o_write.
REQ-015 SHALL have port o_data  output  DATA_W  issued data, valid when o_write.
REQ-016 SHALL have port o_clkgate  output  1  bank clock-gate enable, equal to o_write.
REQ-017 SHALL have port o_nDropped  output  8  count of rejected requests.

Function
REQ-018 Push SHALL occur when i_valid && o_ready && !i_flush (plus address check, REQ-031).
REQ-019 o_ready SHALL be (count < DEPTH), derived only from registered state, never from i_valid.
REQ-020 Pop SHALL occur when count != 0 && !i_stall && !i_flush; o_write/o_addr/o_data SHALL be registered from the popped entry, asserted the following cycle.
REQ-021 Minimum latency SHALL be 2 cycles: request accepted at edge N into empty queue -> o_write high in cycle after edge N+1.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; push into a full queue SHALL NOT occur even if a pop happens in the same cycle.
REQ-023 Requests SHALL issue in strict acceptance order; pointers SHALL wrap modulo DEPTH.
REQ-024 When o_write is low, o_addr and o_data SHALL hold their last issued values.
REQ-025 i_flush SHALL take priority over push and pop: next cycle count = 0, pointers = 0, o_write = 0; in-flight o_write already asserted in the flush cycle is unaffected.
REQ-026 i_stall high SHALL force o_write low next cycle and retain all entries.
REQ-027 o_nDropped SHALL saturate at 255 and never wrap.

Reset
REQ-028 On rst SHALL asynchronously set count = 0, pointers = 0, o_write = 0, o_clkgate = 0, o_addr = 0, o_data = 0, o_nDropped = 0.
REQ-029 o_ready SHALL be 1 during and immediately after reset deassertion.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; no o_write pulse SHALL follow deassertion without a new push.

Configuration
REQ-031 With macro REG_WR_QUEUE_ADDRCHECK_EN defined, a handshaking request (i_valid && o_ready && !i_flush) whose i_addr is not ADDR_RED/ADDR_BLUE/ADDR_GREEN SHALL be consumed but not pushed, and o_nDropped SHALL increment.
REQ-032 Without REG_WR_QUEUE_ADDRCHECK_EN, every handshaking request SHALL be pushed and o_nDropped SHALL be constant 0.

Verification
REQ-033 Reset release, single push addr 123 data 0xA5 -> o_write high exactly one cycle, 2 cycles after acceptance, o_addr=123, o_data=0xA5, o_clkgate=1.
REQ-034 Push 4 requests with i_stall=1 (DEPTH=4) -> o_ready=0 after 4th; 5th i_valid not accepted; release stall -> 4 strobes on consecutive cycles in order, o_ready returns to 1.
REQ-035 Full queue, i_valid=1 and pop same cycle -> no push that cycle; count goes 4->3, push accepted next cycle.
REQ-036 Queue holding 3 entries, i_flush=1 with i_valid=1 -> no push; next cycle count=0, no further o_write.
REQ-037 ADDRCHECK_EN defined: push addr 100 then 456 -> only 456 issued, o_nDropped=1; 300 bad pushes -> o_nDropped=255.
REQ-038 rst asserted with 2 entries queued and o_write high -> o_write, o_clkgate, o_addr, o_data, o_nDropped all 0 immediately; no strobe after release.
